mine_placer: RTL and testbench

Sequences mine placement for a new game once the difficulty has been chosen. On a `start` pulse from level selection it latches the mine count and grid size. It then fills an internal 16x16 mine map with pseudo-random, non-duplicate positions, never placing a mine on the safe cell. The map is read back through a registered query port by board drawing and click handling.

---
 rtl/mine_placer.sv | 181 ++++++++++++++++++
 tb/tb_mine_placer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mine_placer.sv
// mine_placer: places pseudo-random, non-duplicate mines into a 16x16 map
// for a new game.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   start         - one-cycle placement request, accepted only while idle
//   mines_in      - requested mine count (0..63)
//   button_num    - grid edge in cells (valid 1..16)
//   safe_x/safe_y - cell that must stay mine-free
//   query_x/y     - map read address
//   is_mine       - registered map bit for the query cell (1-cycle latency)
//   busy          - high while placement runs
//   done          - one-cycle pulse when placement completes
//   mines_placed  - number of mines currently in the map
module mine_placer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] mines_in,
  input  logic [4:0] button_num,
  input  logic [3:0] safe_x,
  input  logic [3:0] safe_y,
  input  logic [3:0] query_x,
  input  logic [3:0] query_y,
  output logic       is_mine,
  output logic       busy,
  output logic       done,
  output logic [5:0] mines_placed
);

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned GRID_W  = 5;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned CELLS_W = 9;
  localparam int unsigned MAP_N   = 256;
  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned MAX_EDGE = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLACE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [LFSR_W-1:0]    r_lfsr;
  logic [MAP_N-1:0]     r_map;
  logic [GRID_W-1:0]    r_grid;
  logic [COORD_W-1:0]   r_safe_x;
  logic [COORD_W-1:0]   r_safe_y;
  logic [CNT_W-1:0]     r_target;
  logic [CNT_W-1:0]     r_count;
  logic                 r_reached;
  logic                 r_is_mine;
  logic                 r_busy;
  logic                 r_done;

  logic [CELLS_W-1:0]   w_cells;
  logic [CELLS_W-1:0]   w_cells_m1;
  logic [CNT_W-1:0]     w_target;
  logic [COORD_W-1:0]   w_cx;
  logic [COORD_W-1:0]   w_cy;
  logic [7:0]           w_idx;
  logic                 w_cand_ok;
  logic                 w_place;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 w_q_in_range;
  logic [LFSR_W-1:0]    w_lfsr_nxt;

  // Fibonacci LFSR x^16+x^14+x^13+x^11, shifting right
  assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5],
                       r_lfsr[LFSR_W-1:1]};

  // Mine target from the requested count, clamped so the safe cell stays free
  assign w_cells    = CELLS_W'(button_num) * CELLS_W'(button_num);
  assign w_cells_m1 = w_cells - CELLS_W'(1);

  always_comb begin
    w_target = '0;
    if (button_num != '0 && button_num <= GRID_W'(MAX_EDGE)) begin
      if (w_cells_m1 < CELLS_W'(mines_in)) begin
        w_target = CNT_W'(w_cells_m1);
      end else begin
        w_target = mines_in;
      end
    end
  end

  // Candidate cell for this cycle
  assign w_cx  = r_lfsr[3:0];
  assign w_cy  = r_lfsr[7:4];
  assign w_idx = {w_cy, w_cx};

  assign w_cand_ok = ({1'b0, w_cx} < r_grid) &&
                     ({1'b0, w_cy} < r_grid) &&
                     !((w_cx == r_safe_x) && (w_cy == r_safe_y)) &&
                     !r_map[w_idx];

  // Placement is gated by the registered count so the target is never overshot
  assign w_place     = (r_state == S_PLACE) && (r_count < r_target) && w_cand_ok;
  assign w_count_nxt = r_count + CNT_W'(w_place);

  assign w_q_in_range = ({1'b0, query_x} < r_grid) && ({1'b0, query_y} < r_grid);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_PLACE;
      S_PLACE:  if (r_reached) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: LFSR, map, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr    <= LFSR_SEED;
      r_map     <= '0;
      r_grid    <= '0;
      r_safe_x  <= '0;
      r_safe_y  <= '0;
      r_target  <= '0;
      r_count   <= '0;
      r_reached <= 1'b0;
      r_is_mine <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_lfsr    <= w_lfsr_nxt;
      r_busy    <= (w_state_nxt == S_PLACE);
      r_done    <= (w_state_nxt == S_FINISH);
      r_is_mine <= w_q_in_range ? r_map[{query_y, query_x}] : 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_grid    <= button_num;
            r_safe_x  <= safe_x;
            r_safe_y  <= safe_y;
            r_target  <= w_target;
            r_count   <= '0;
            r_map     <= '0;
            r_reached <= 1'b0;
          end
        end
        S_PLACE: begin
          if (w_place) begin
            r_map[w_idx] <= 1'b1;
          end
          r_count <= w_count_nxt;
          // Completion seen one edge after the last mine lands
          r_reached <= (w_count_nxt == r_target);
        end
        default: begin
          r_reached <= 1'b0;
        end
      endcase
    end
  end

  assign is_mine      = r_is_mine;
  assign busy         = r_busy;
  assign done         = r_done;
  assign mines_placed = r_count;

endmodule

// File: tb/tb_mine_placer.sv
// Testbench for mine_placer: directed and random games checked against a
// behavioural model that replays the LFSR sequence and the placement rules.
module tb_mine_placer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] mines_in;
  logic [4:0] button_num;
  logic [3:0] safe_x, safe_y, query_x, query_y;
  logic       is_mine, busy, done;
  logic [5:0] mines_placed;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_lfsr;

  mine_placer #(.LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .mines_in(mines_in),
    .button_num(button_num), .safe_x(safe_x), .safe_y(safe_y),
    .query_x(query_x), .query_y(query_y), .is_mine(is_mine),
    .busy(busy), .done(done), .mines_placed(mines_placed)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Free-running reference copy of the LFSR, following its documented behaviour
  always @(posedge clk) m_lfsr <= rst ? SEED : step(m_lfsr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference placement: replay candidates from the LFSR until the target is met
  function automatic void model(input logic [15:0] l0, input int bn, input int sx,
                                input int sy, input int mines,
                                output bit [255:0] map, output int tgt, output int att);
    int cells, cnt, cx, cy;
    logic [15:0] l;
    cells = bn * bn;
    if (bn == 0 || bn > 16) tgt = 0;
    else if (cells - 1 < mines) tgt = cells - 1;
    else tgt = mines;
    map = '0;
    cnt = 0;
    att = 0;
    l = l0;
    while (cnt < tgt && att < 70000) begin
      cx = int'(l[3:0]);
      cy = int'(l[7:4]);
      if (cx < bn && cy < bn && !(cx == sx && cy == sy) && !map[cy*16+cx]) begin
        map[cy*16+cx] = 1'b1;
        cnt++;
      end
      att++;
      l = step(l);
    end
  endfunction

  // Read the whole map through the query port and compare with the model
  task automatic check_map(input string tag, input int bn, input int sx, input int sy,
                           input bit [255:0] map, input int tgt);
    int ones;
    logic safe_obs;
    bit exp;
    ones = 0;
    safe_obs = 1'b0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        query_x = 4'(x);
        query_y = 4'(y);
        tick();
        exp = (x < bn && y < bn) ? map[y*16+x] : 1'b0;
        check($sformatf("%s_cell_%0d_%0d", tag, x, y), 32'(is_mine), 32'(exp));
        if (is_mine === 1'b1) ones++;
        if (x == sx && y == sy) safe_obs = is_mine;
      end
    end
    check({tag, "_ones"}, 32'(ones), 32'(tgt));
    check({tag, "_safe"}, 32'(safe_obs), 32'd0);
  endtask

  task automatic run_game(input string tag, input int mines, input int bn,
                          input int sx, input int sy, input int poke);
    bit [255:0] map;
    int tgt, att, d, ndone, at, both;
    mines_in   = 6'(mines);
    button_num = 5'(bn);
    safe_x     = 4'(sx);
    safe_y     = 4'(sy);
    start      = 1'b1;
    tick();
    start = 1'b0;
    model(m_lfsr, bn, sx, sy, mines, map, tgt, att);
    check({tag, "_busy_k"}, 32'(busy), 32'd1);
    check({tag, "_done_k"}, 32'(done), 32'd0);
    check({tag, "_placed_k"}, 32'(mines_placed), 32'd0);
    d = (tgt == 0) ? 2 : att + 1;
    ndone = 0;
    at = -1;
    both = 0;
    for (int i = 1; i <= d + 3; i++) begin
      if (i == poke) begin
        start      = 1'b1;
        mines_in   = 6'd5;
        button_num = 5'd4;
      end
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (at < 0) at = i;
      end
      if (busy === 1'b1 && done === 1'b1) both++;
    end
    check({tag, "_done_count"}, 32'(ndone), 32'd1);
    check({tag, "_done_edge"}, 32'(at), 32'(d));
    check({tag, "_busy_done_overlap"}, 32'(both), 32'd0);
    check({tag, "_placed"}, 32'(mines_placed), 32'(tgt));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_map(tag, bn, sx, sy, map, tgt);
  endtask

  initial begin
    bit [255:0] zmap;
    int ndone;
    zmap = '0;
    rst = 1'b1;
    start = 1'b0;
    mines_in = '0;
    button_num = '0;
    safe_x = '0;
    safe_y = '0;
    query_x = '0;
    query_y = '0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_placed", 32'(mines_placed), 32'd0);
    check_map("rst_map", 16, 0, 0, zmap, 0);

    // Directed levels
    run_game("lvl1", 8, 8, 3, 3, 0);
    run_game("lvl3", 50, 16, 0, 0, 0);
    run_game("clamp", 63, 4, 1, 2, 0);
    run_game("zero", 0, 8, 2, 2, 0);
    run_game("grid20", 5, 20, 0, 0, 0);
    run_game("grid1", 5, 1, 0, 0, 0);

    // start pulsed while placing must not restart
    run_game("poke", 50, 16, 7, 7, 3);

    // Reset in the middle of placement
    mines_in = 6'd50;
    button_num = 5'd16;
    safe_x = 4'd5;
    safe_y = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_placed", 32'(mines_placed), 32'd0);
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    check_map("midrst_map", 16, 5, 5, zmap, 0);
    run_game("after_rst", 12, 10, 9, 0, 0);

    // Random games
    for (int g = 0; g < 6; g++) begin
      run_game($sformatf("rnd%0d", g), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 20)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
